mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit: the multi-cycle companion to the single-cycle ALU.
- Executes all eight RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in EX beside the ALU. The pipeline stalls on busy and picks up C on done.
- Uses a start/busy/done handshake and supports flush for branch/trap kill.

---
 rtl/mdu_iter.sv | 166 ++++++++++++++++
 tb/tb_mdu_iter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Start/busy/done handshake with flush; one result bit per cycle over WIDTH cycles.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rD1,
    input  logic [WIDTH-1:0] rD2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   c_q, c_d;

    op_e                op_in;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_sel, div_fix;

    // Operand sign handling at acceptance: magnitudes for signed ops, result sign recorded.
    always_comb begin
        op_in = op_e'(md_op);
        sgn_a = ((op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                 (op_in == OP_DIV)  || (op_in == OP_REM)) && rD1[WIDTH-1];
        sgn_b = ((op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM)) && rD2[WIDTH-1];
        mag_a = sgn_a ? (~rD1 + 1'b1) : rD1;
        mag_b = sgn_b ? (~rD2 + 1'b1) : rD2;
    end

    // Multiply: acc holds {partial product, remaining multiplier}; add then shift right.
    // Divide: acc holds {remainder, dividend/quotient}; quotient bits enter at the LSB.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod_fix  = neg_q ? (~mul_next + 1'b1) : mul_next;
        div_sel   = op_q[1] ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
        div_fix   = neg_q ? (~div_sel + 1'b1) : div_sel;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d    = op_in;
                    cnt_d   = '0;
                    state_d = CALC;
                    if (op_in[2]) begin
                        neg_d = op_in[1] ? sgn_a : (sgn_a ^ sgn_b);
                        b_d   = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                        if (rD2 == '0) begin
                            state_d = DONE;
                            c_d     = op_in[1] ? rD1 : '1;
                        end else if (!op_in[0] && (rD1 == MIN_INT) && (rD2 == '1)) begin
                            state_d = DONE;
                            c_d     = op_in[1] ? '0 : MIN_INT;
                        end
                    end else begin
                        neg_d = sgn_a ^ sgn_b;
                        b_d   = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = DONE;
                    if (op_q[2]) begin
                        c_d = div_fix;
                    end else if (op_q == OP_MUL) begin
                        c_d = prod_fix[WIDTH-1:0];
                    end else begin
                        c_d = prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            op_d    = op_q;
            neg_d   = neg_q;
            b_d     = b_q;
            acc_d   = acc_q;
            c_d     = c_q;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign C    = c_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed RV32M results, latency, handshake, abort.
module tb_mdu_iter;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = '0;
    logic [31:0] rD1 = '0;
    logic [31:0] rD2 = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] C;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .start     (start),
        .md_op     (md_op),
        .rD1       (rD1),
        .rD2       (rD2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .C         (C)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives start for one cycle (operands scrambled afterwards) and waits for done.
    // lat counts edges from the start cycle to the first cycle with done high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cyc,
                          output int both);
        start = 1'b1; md_op = op; rD1 = a; rD2 = b;
        lat = 0; busy_cyc = 0; both = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge cpu_clk); #1;
            if (i == 0) begin
                start = 1'b0; rD1 = ~a; rD2 = a ^ b; md_op = ~op;
            end
            lat++;
            if (busy) busy_cyc++;
            if (busy && done) both++;
            if (done) break;
        end
        res = C;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cpu_clk); #1;
        end
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] res;
        int lat, bc, both, cnt;

        tick(2);
        cpu_rst_n = 1'b1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_C", C, 32'd0);

        vecs.push_back('{"mul_ff",    MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
        vecs.push_back('{"mulhu_ff",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{"mulh_m2x3", MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33});
        vecs.push_back('{"mulhsu",    MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        vecs.push_back('{"mul_small", MUL,    32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 33});
        vecs.push_back('{"div_m7_2",  DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_m7_2",  REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{"divu_100",  DIVU,   32'd100,      32'd7,        32'd14,       33});
        vecs.push_back('{"remu_100",  REMU,   32'd100,      32'd7,        32'd2,        33});
        vecs.push_back('{"div_by0",   DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"remu_by0",  REMU,   32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{"div_ovf",   DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"rem_ovf",   REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1});

        foreach (vecs[k]) begin
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, res, lat, bc, both);
            check({vecs[k].tag, "_C"}, res, vecs[k].exp);
            check({vecs[k].tag, "_lat"}, lat, vecs[k].lat);
            check({vecs[k].tag, "_busy"}, bc, vecs[k].lat - 1);
            check({vecs[k].tag, "_overlap"}, both, 32'd0);
            tick(1);
            check({vecs[k].tag, "_done_pulse"}, {31'b0, done}, 32'd0);
            check({vecs[k].tag, "_C_hold"}, C, vecs[k].exp);
        end

        // Second op started in the DONE cycle of the first.
        run_op(DIVU, 32'd100, 32'd7, res, lat, bc, both);
        check("b2b_first_C", res, 32'd14);
        run_op(REMU, 32'd100, 32'd7, res, lat, bc, both);
        check("b2b_second_C", res, 32'd2);
        check("b2b_second_lat", lat, 32'd33);
        tick(2);

        // Start pulsed mid-CALC must be ignored.
        start = 1'b1; md_op = DIVU; rD1 = 32'd100; rD2 = 32'd7;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge cpu_clk); #1;
            cnt++;
            if (i == 0) start = 1'b0;
            if (i == 4) begin start = 1'b1; md_op = MUL; rD1 = 32'd3; rD2 = 32'd4; end
            if (i == 5) start = 1'b0;
            if (done) break;
        end
        check("midstart_C", C, 32'd14);
        check("midstart_lat", cnt, 32'd33);
        tick(2);

        // Start together with flush from IDLE is dropped.
        start = 1'b1; flush = 1'b1; md_op = MUL; rD1 = 32'd2; rD2 = 32'd2;
        tick(1);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'd0);
        tick(1);
        check("flush_start_busy2", {31'b0, busy}, 32'd0);

        // Flush at CALC cycle 10.
        start = 1'b1; md_op = MUL; rD1 = 32'd7; rD2 = 32'd6;
        tick(1);
        start = 1'b0;
        tick(10);
        check("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_C", C, 32'd14);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done || busy) cnt++;
        end
        check("flush_quiet", cnt, 32'd0);
        check("flush_C_later", C, 32'd14);

        // Reset mid-CALC.
        start = 1'b1; md_op = MULHU; rD1 = 32'hFFFFFFFF; rD2 = 32'hFFFFFFFF;
        tick(1);
        start = 1'b0;
        tick(5);
        cpu_rst_n = 1'b0;
        tick(1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_C", C, 32'd0);
        cpu_rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done || busy) cnt++;
        end
        check("rst_quiet", cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
